// File: rtl/gray_fifo_pkg.sv
// Shared helpers for the Gray-coded FIFO pointer controllers (write and read side).
// Functions work on a wide container type; callers zero-extend their pointers
// into it and size-cast the result back down to their own pointer width.
package gray_fifo_pkg;

  localparam int MAX_PTR_W = 32;

  typedef logic [MAX_PTR_W-1:0] ptr_t;

  // Pointer width for a given RAM address width: one extra lap bit.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits decode to zero.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Full in the Gray domain: top two bits inverted, the rest equal.
  // w is the real pointer width of the caller.
  function automatic logic full_match(input ptr_t wgray, input ptr_t rgray, input int w);
    ptr_t mask;
    mask = ptr_t'(3) << (w - 2);
    return wgray == (rgray ^ mask);
  endfunction

endpackage

// File: rtl/gray_ptr_cnt.sv
// Registered binary + Gray pointer counter with increment enable and
// synchronous active-high reset. Exposes both the current and the next
// values so the owner can compute flags on the post-increment pointer.
module gray_ptr_cnt
  import gray_fifo_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] bin,
  output logic [W-1:0] gray,
  output logic [W-1:0] bin_next,
  output logic [W-1:0] gray_next
);

  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] gray_q, gray_d;

  // Next pointer: increment modulo 2**W, Gray derived from the next binary value.
  always_comb begin
    bin_d  = bin_q + {{(W-1){1'b0}}, inc};
    gray_d = W'(bin2gray(ptr_t'(bin_d)));
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign bin       = bin_q;
  assign gray      = gray_q;
  assign bin_next  = bin_d;
  assign gray_next = gray_d;

endmodule

// File: rtl/async_fifo_wptr_ctrl.sv
// Write-side pointer controller of the asynchronous FIFO: binary write pointer,
// Gray copy for the read domain, registered full flag and occupancy level.
// Optional feature macro: ALMOST_FULL_EN adds the registered out_almost_full port
// (asserted while level >= AF_THRESH).
module async_fifo_wptr_ctrl
  import gray_fifo_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int AF_THRESH = 120
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_wr_valid,
  output logic              out_wr_ready,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [ADDR_W:0]   out_wptr_gray,
  input  logic [ADDR_W:0]   in_rptr_gray_sync,
  output logic              out_full,
`ifdef ALMOST_FULL_EN
  output logic              out_almost_full,
`endif
  output logic [ADDR_W:0]   out_level
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(1 << ADDR_W);

  logic [PTR_W-1:0] wbin, wgray, wbin_next, wgray_next;
  logic [PTR_W-1:0] rbin, diff;
  logic [PTR_W-1:0] level_d, level_q;
  logic             full_d, full_q;
  logic             unused_wbin_msb;

  gray_ptr_cnt #(.W(PTR_W)) u_wptr (
    .clk       (in_clk),
    .rst       (in_rst),
    .inc       (out_wr_en),
    .bin       (wbin),
    .gray      (wgray),
    .bin_next  (wbin_next),
    .gray_next (wgray_next)
  );

  // Producer handshake and RAM write port; no strobe while reset is applied.
  always_comb begin
    out_wr_ready = !full_q;
    out_wr_en    = in_wr_valid && out_wr_ready && !in_rst;
    out_wr_addr  = wbin[ADDR_W-1:0];
  end

  // The lap bit only matters for full/level, not for addressing.
  assign unused_wbin_msb = wbin[ADDR_W];

  // Level and full on the post-write pointer against the current read pointer;
  // a level above DEPTH can only come from a transient/corrupt pointer, so clamp.
  always_comb begin
    rbin    = PTR_W'(gray2bin(ptr_t'(in_rptr_gray_sync)));
    diff    = wbin_next - rbin;
    level_d = (diff > DEPTH_P) ? DEPTH_P : diff;
    full_d  = full_match(ptr_t'(wgray_next), ptr_t'(in_rptr_gray_sync), PTR_W) ||
              (level_d == DEPTH_P);
  end

  // Flag and level registers.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      level_q <= '0;
      full_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      full_q  <= full_d;
    end
  end

`ifdef ALMOST_FULL_EN
  logic af_d, af_q;

  // Almost-full threshold on the same next-level value as full.
  always_comb begin
    af_d = (level_d >= PTR_W'(AF_THRESH));
  end

  // Almost-full register.
  always_ff @(posedge in_clk) begin
    if (in_rst) af_q <= 1'b0;
    else        af_q <= af_d;
  end

  assign out_almost_full = af_q;
`endif

  assign out_wptr_gray = wgray;
  assign out_full      = full_q;
  assign out_level     = level_q;

endmodule

// File: tb/tb_async_fifo_wptr_ctrl.sv
// Scoreboard bench for async_fifo_wptr_ctrl (ADDR_W=7, AF_THRESH=120).
// The driver keeps a counting model (total writes / total reads as integers)
// and pushes the expected per-cycle outputs; the monitor pops and compares.
module tb_async_fifo_wptr_ctrl;

  localparam int DEPTH = 128;
  localparam int AF    = 120;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b0;
  logic       in_wr_valid = 1'b0;
  logic       out_wr_ready, out_wr_en, out_full;
  logic [6:0] out_wr_addr;
  logic [7:0] out_wptr_gray, out_level;
  logic [7:0] in_rptr_gray_sync = 8'h00;
`ifdef ALMOST_FULL_EN
  logic       out_almost_full;
`endif

  async_fifo_wptr_ctrl #(.ADDR_W(7), .AF_THRESH(AF)) dut (
    .in_clk            (in_clk),
    .in_rst            (in_rst),
    .in_wr_valid       (in_wr_valid),
    .out_wr_ready      (out_wr_ready),
    .out_wr_en         (out_wr_en),
    .out_wr_addr       (out_wr_addr),
    .out_wptr_gray     (out_wptr_gray),
    .in_rptr_gray_sync (in_rptr_gray_sync),
    .out_full          (out_full),
`ifdef ALMOST_FULL_EN
    .out_almost_full   (out_almost_full),
`endif
    .out_level         (out_level)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    bit         chk;
    bit         en;
    logic [7:0] gray;
    int         level;
    bit         full;
    bit         af;
  } exp_t;

  exp_t exp_q[$];
  int   addr_q[$];

  int errors = 0;
  int checks = 0;

  // Model: totals of accepted writes and read-pointer position.
  int m_wr = 0, m_rd = 0, m_level = 0;
  bit m_full = 0, m_af = 0, m_known = 0;

  function automatic logic [7:0] gray8(input int n);
    logic [7:0] b;
    b = 8'(n % 256);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input bit v, input bit r, input int rd_new);
    exp_t e;
    bit acc;
    @(posedge in_clk); #1;
    if (r) rd_new = 0;
    in_rst = r;
    in_wr_valid = v;
    in_rptr_gray_sync = gray8(rd_new);
    acc = v && !r && !m_full;
    e.chk = m_known; e.en = acc; e.gray = gray8(m_wr);
    e.level = m_level; e.full = m_full; e.af = m_af;
    exp_q.push_back(e);
    if (acc) addr_q.push_back(m_wr % DEPTH);
    if (r) begin
      m_wr = 0; m_rd = 0; m_level = 0; m_full = 0; m_af = 0; m_known = 1;
    end else begin
      m_wr += int'(acc);
      m_rd = rd_new;
      m_level = m_wr - m_rd;
      if (m_level > DEPTH) m_level = DEPTH;
      m_full = (m_level == DEPTH);
      m_af = (m_level >= AF);
    end
  endtask

  // Monitor: one expectation per cycle, plus one address per strobe.
  always @(negedge in_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("wr_en", int'(out_wr_en), int'(e.en));
      if (out_wr_en === 1'b1) begin
        if (addr_q.size() == 0) check("unexpected_strobe", 1, 0);
        else check("wr_addr", int'(out_wr_addr), addr_q.pop_front());
      end
      if (e.chk) begin
        check("wptr_gray", int'(out_wptr_gray), int'(e.gray));
        check("level", int'(out_level), e.level);
        check("full", int'(out_full), int'(e.full));
        check("wr_ready", int'(out_wr_ready), int'(!e.full));
`ifdef ALMOST_FULL_EN
        check("almost_full", int'(out_almost_full), int'(e.af));
`endif
      end
    end
  end

  initial begin
    // Reset with valid held high.
    step(1, 1, 0);
    step(1, 1, 0);
    // Fill: 130 cycles of valid with the reader parked at 0.
    repeat (130) step(1, 0, 0);
    // Drain release: one read, then one accepted write, then full again.
    step(0, 0, 1);
    repeat (3) step(1, 0, 1);
    // Wrap: reader advances whenever behind; ~300 writes at steady level.
    repeat (320) step(1, 0, (m_rd < m_wr) ? m_rd + 1 : m_rd);
    // Reset mid-fill at level 50.
    step(0, 1, 0);
    repeat (50) step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    // Random traffic.
    repeat (1500) begin
      bit v;
      int rd;
      v  = 1'($urandom_range(0, 3) != 0);
      rd = (m_rd < m_wr && $urandom_range(0, 2) == 0) ? m_rd + 1 : m_rd;
      step(v, 0, rd);
    end
    repeat (2) step(0, 0, m_rd);
    @(posedge in_clk);
    @(negedge in_clk); #1;
    check("scoreboard_drained", exp_q.size() + addr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
